nrzi_rx_deser: RTL

Toggle-encoded (NRZI) serial receiver: the decode end of the T-flip-flop line encoder, where a transmitted 1 toggles the line and a 0 holds it. Samples the line on a bit strobe, recovers bits by comparing each sample with the previous one, hunts for a sync byte, then deserialises a fixed-length frame into bytes. Bytes are delivered over a valid/ready handshake to the downstream byte consumer.

---
 rtl/nrzi_pkg.sv | 17 +
 rtl/nrzi_bit_dec.sv | 34 +++
 rtl/nrzi_rx_deser.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/nrzi_pkg.sv
// nrzi_pkg: shared types and constants for the NRZI receive path.
//   nrzi_state_t   : receiver FSM state (HUNT = searching for sync,
//                    DATA = deserialising frame bytes)
//   NRZI_STUFF_RUN : run of decoded 1s after which a stuffed 0 follows
//   NRZI_IDLE_LVL  : idle line level, also the reset value of the
//                    previous-sample register in the bit decoder
package nrzi_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    DATA = 1'b1
  } nrzi_state_t;

  localparam int unsigned NRZI_STUFF_RUN = 6;
  localparam logic        NRZI_IDLE_LVL  = 1'b0;

endpackage

// File: rtl/nrzi_bit_dec.sv
// nrzi_bit_dec: NRZI (toggle) bit decoder. A decoded 1 is a change of
// line level between consecutive strobed samples, a 0 is no change.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (previous level -> idle)
//   i_din     : line level, already synchronised to clk
//   i_bit_en  : sample strobe; i_din is only looked at when high
//   o_bit     : decoded bit, meaningful while o_bit_vld is high
//   o_bit_vld : decoded bit valid (same cycle as i_bit_en)
module nrzi_bit_dec
  import nrzi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  input  logic i_bit_en,
  output logic o_bit,
  output logic o_bit_vld
);

  logic r_prev_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_lvl <= NRZI_IDLE_LVL;
    end else if (i_bit_en) begin
      r_prev_lvl <= i_din;
    end
  end

  assign o_bit     = i_din ^ r_prev_lvl;
  assign o_bit_vld = i_bit_en;

endmodule

// File: rtl/nrzi_rx_deser.sv
// nrzi_rx_deser: NRZI serial receiver. Decodes the strobed line, hunts
// for SYNC_PAT on a sliding window, then deserialises FRAME_LEN bytes
// (LSB first) and hands them out over a valid/ready register.
// Parameters:
//   SYNC_PAT   : sync byte, matched on decoded bits, LSB first
//   FRAME_LEN  : data bytes per frame (1..255)
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : NRZI line level
//   bit_en     : one-cycle sample strobe
//   data       : received byte, LSB = first bit received
//   valid      : data holds an unconsumed byte
//   ready      : consumer accepts data when valid && ready
//   frame_done : one-cycle pulse with the last byte of a frame
//   overrun    : sticky, a byte was dropped while valid was pending
//   busy       : FSM is not in HUNT
// Build option:
//   NRZI_STUFF_EN : when defined, destuff in DATA state (a 0 following
//                   six decoded 1s is dropped; a 1 there aborts the frame)
module nrzi_rx_deser
  import nrzi_pkg::*;
#(
  parameter logic [7:0]  SYNC_PAT  = 8'h7E,
  parameter int unsigned FRAME_LEN = 4
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       bit_en,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_done,
  output logic       overrun,
  output logic       busy
);

  nrzi_state_t r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_done;
  logic        r_overrun;

  logic       w_dec_bit;
  logic       w_bit_vld;
  logic [7:0] w_shift_in;
  logic       w_stuff_skip;
  logic       w_stuff_err;
  logic       w_data_bit;
  logic       w_byte_done;
  logic       w_last_byte;
  logic       w_load;

  nrzi_bit_dec u_bit_dec (
    .clk       (clk),
    .rst       (rst),
    .i_din     (din),
    .i_bit_en  (bit_en),
    .o_bit     (w_dec_bit),
    .o_bit_vld (w_bit_vld)
  );

  // Shifting in at the MSB leaves the first received bit at the LSB once
  // eight bits have gone in; the same path serves sync hunt and assembly.
  assign w_shift_in = {w_dec_bit, r_shift[7:1]};

`ifdef NRZI_STUFF_EN
  logic [2:0] r_ones;

  // Held at zero throughout HUNT, so it is zero on entry to DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones <= '0;
    end else if (w_bit_vld) begin
      if (r_state == HUNT || w_stuff_skip || w_stuff_err || !w_dec_bit) begin
        r_ones <= '0;
      end else begin
        r_ones <= r_ones + 3'd1;
      end
    end
  end

  assign w_stuff_skip = w_bit_vld && (r_state == DATA) &&
                        (r_ones == 3'(NRZI_STUFF_RUN)) && !w_dec_bit;
  assign w_stuff_err  = w_bit_vld && (r_state == DATA) &&
                        (r_ones == 3'(NRZI_STUFF_RUN)) && w_dec_bit;
`else
  assign w_stuff_skip = 1'b0;
  assign w_stuff_err  = 1'b0;
`endif

  assign w_data_bit  = w_bit_vld && (r_state == DATA) && !w_stuff_skip && !w_stuff_err;
  assign w_byte_done = w_data_bit && (r_bit_cnt == 3'd7);
  assign w_last_byte = w_byte_done && (r_byte_cnt == 8'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_bit_vld) begin
        case (r_state)
          HUNT: begin
            r_shift <= w_shift_in;
            if (w_shift_in == SYNC_PAT) begin
              r_state    <= DATA;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
            end
          end
          DATA: begin
            if (w_stuff_err) begin
              r_state <= HUNT;
              r_shift <= '0;
            end else if (w_data_bit) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
                if (w_last_byte) begin
                  r_frame_done <= 1'b1;
                  r_state      <= HUNT;
                  r_shift      <= '0;
                end
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  // A completed byte may load into a slot being emptied in the same cycle.
  assign w_load = w_byte_done && (!r_valid || ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_shift_in;
      r_valid <= 1'b1;
    end else begin
      if (w_byte_done) begin
        r_overrun <= 1'b1;
      end
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign busy       = (r_state != HUNT);

endmodule
